seq_alu: RTL and testbench



---
 rtl/seq_alu.sv | 247 ++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU. Base integer ops complete in one cycle; MUL/MULH
// (and, when SEQ_ALU_DIV_EN is defined, DIV/DIVU/REM/REMU) iterate one bit per
// cycle behind a start/busy/done handshake. Without SEQ_ALU_DIV_EN, op codes
// 12-15 finish in one cycle with result 0 and no divider hardware is built.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; quick ops and divide special cases finish here
// CALC  | one multiply/divide iteration per cycle, counted by r_cnt
// FIX   | sign correction of the magnitude result, write outputs, pulse done
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             sf,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_MULH = 4'd11;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_REM  = 4'd14;
`endif

  // The first iteration happens at the capture edge, so CALC starts at 1.
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH-1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  logic [SHW:0]       r_cnt;
  logic [2*WIDTH-1:0] r_acc;      // mul: {hi, lo/multiplier}; div: {rem, quo/dividend}
  logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
  logic [1:0]         r_sel;      // 0 MUL, 1 MULH, 2 quotient, 3 remainder
  logic               r_neg;
  logic               r_sf_cap;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_sf;
  logic               r_busy;
  logic               r_done;

  logic [SHW-1:0]     w_shamt;
  logic               w_sf_in;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_iter;
  logic [1:0]         w_sel_in;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_imm_res;
  logic [WIDTH-1:0]   w_fix_res;
  logic [WIDTH-1:0]   w_opnd_in;
  logic [WIDTH-1:0]   w_mulh_neg;
  logic [2*WIDTH-1:0] w_acc_in;
  logic [2*WIDTH-1:0] w_step_acc;
  logic [WIDTH:0]     w_sum;
`ifdef SEQ_ALU_DIV_EN
  logic               w_div_op;
  logic               w_special;
  logic               w_step_div;
  logic [WIDTH+1:0]   w_diff;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
`endif

  assign w_shamt = src_b[SHW-1:0];
  assign w_sf_in = src_b > src_a;

`ifdef SEQ_ALU_DIV_EN
  assign w_div_op   = &op[3:2];
  assign w_special  = w_div_op && ((src_b == '0) ||
                      ((op == OP_DIV || op == OP_REM) &&
                       src_a == {1'b1, {(WIDTH-1){1'b0}}} && &src_b));
  assign w_iter     = (op == OP_MUL || op == OP_MULH) || (w_div_op && !w_special);
  assign w_signed   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign w_sel_in   = w_div_op ? {1'b1, op[1]} : {1'b0, op[0]};
  assign w_step_div = (r_state == S_IDLE) ? w_div_op : r_sel[1];
  assign w_quo      = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem      = r_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
`else
  assign w_iter     = (op == OP_MUL || op == OP_MULH);
  assign w_signed   = (op == OP_MULH);
  assign w_sel_in   = {1'b0, op[0]};
`endif

  assign w_a_neg = w_signed & src_a[WIDTH-1];
  assign w_b_neg = w_signed & src_b[WIDTH-1];
  assign w_mag_a = w_a_neg ? -src_a : src_a;
  assign w_mag_b = w_b_neg ? -src_b : src_b;

  // High word of the two's-complement negated 2*WIDTH product.
  assign w_mulh_neg = ~r_acc[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, ~|r_acc[WIDTH-1:0]};

  // Single-cycle results, with divide special cases overriding.
  always_comb begin
    w_imm_res = '0;
    case (op)
      OP_ADD:  w_imm_res = src_a + src_b;
      OP_SUB:  w_imm_res = src_a - src_b;
      OP_AND:  w_imm_res = src_a & src_b;
      OP_OR:   w_imm_res = src_a | src_b;
      OP_XOR:  w_imm_res = src_a ^ src_b;
      OP_SLT:  w_imm_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLL:  w_imm_res = src_a << w_shamt;
      OP_SRL:  w_imm_res = src_a >> w_shamt;
      OP_SRA:  w_imm_res = $signed(src_a) >>> w_shamt;
      OP_SLTU: w_imm_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
      default: w_imm_res = '0;
    endcase
`ifdef SEQ_ALU_DIV_EN
    if (w_div_op) begin
      if (src_b == '0) w_imm_res = op[1] ? src_a : '1;
      else             w_imm_res = op[1] ? '0 : src_a;
    end
`endif
  end

  // Iteration input: fresh magnitudes at capture, otherwise the running state.
  always_comb begin
    w_acc_in  = r_acc;
    w_opnd_in = r_opnd;
    if (r_state == S_IDLE) begin
`ifdef SEQ_ALU_DIV_EN
      w_acc_in  = {{WIDTH{1'b0}}, w_div_op ? w_mag_a : w_mag_b};
      w_opnd_in = w_div_op ? w_mag_b : w_mag_a;
`else
      w_acc_in  = {{WIDTH{1'b0}}, w_mag_b};
      w_opnd_in = w_mag_a;
`endif
    end
  end

  // One shift-add multiply step, or one restoring-divide step.
  always_comb begin
    w_sum      = {1'b0, w_acc_in[2*WIDTH-1:WIDTH]} + (w_acc_in[0] ? {1'b0, w_opnd_in} : '0);
    w_step_acc = {w_sum, w_acc_in[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    w_diff = {1'b0, w_acc_in[2*WIDTH-1:WIDTH-1]} - {2'b00, w_opnd_in};
    if (w_step_div) begin
      if (w_diff[WIDTH+1:WIDTH] == 2'b00)
        w_step_acc = {w_diff[WIDTH-1:0], w_acc_in[WIDTH-2:0], 1'b1};
      else
        w_step_acc = {w_acc_in[2*WIDTH-2:0], 1'b0};
    end
`else
`endif
  end

  // Final result selection with sign correction.
  always_comb begin
    w_fix_res = r_acc[WIDTH-1:0];
    case (r_sel)
      2'd1:    w_fix_res = r_neg ? w_mulh_neg : r_acc[2*WIDTH-1:WIDTH];
`ifdef SEQ_ALU_DIV_EN
      2'd2:    w_fix_res = w_quo;
      2'd3:    w_fix_res = w_rem;
`endif
      default: w_fix_res = r_acc[WIDTH-1:0];
    endcase
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_sel    <= '0;
      r_neg    <= 1'b0;
      r_sf_cap <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_sf     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_iter) begin
              r_acc    <= w_step_acc;
              r_opnd   <= w_opnd_in;
              r_sel    <= w_sel_in;
              r_neg    <= (w_sel_in == 2'd3) ? w_a_neg : (w_a_neg ^ w_b_neg);
              r_sf_cap <= w_sf_in;
              r_cnt    <= CNT_ONE;
              r_busy   <= 1'b1;
              r_state  <= S_CALC;
            end else begin
              r_result <= w_imm_res;
              r_zero   <= (w_imm_res == '0);
              r_sf     <= w_sf_in;
              r_done   <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_step_acc;
          if (r_cnt == CNT_LAST) r_state <= S_FIX;
          else                   r_cnt   <= r_cnt + CNT_ONE;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_zero   <= (w_fix_res == '0);
          r_sf     <= r_sf_cap;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_cnt    <= '0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result = r_result;
  assign zero   = r_zero;
  assign sf     = r_sf;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=32). Expectations follow SEQ_ALU_DIV_EN the same
// way the design does.
module tb_seq_alu;
  localparam int W = 32;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic [W-1:0]  result;
  logic          zero;
  logic          sf;
  logic          busy;
  logic          done;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .result(result), .zero(zero),
    .sf(sf), .busy(busy), .done(done)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        s;
    string       name;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && done === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: done=1 result=%h, expected no done", result);
      end else begin
        e = sb.pop_front();
        if (result !== e.res || zero !== e.z || sf !== e.s) begin
          n_err++;
          $display("FAIL %s: result=%h zero=%b sf=%b, expected result=%h zero=%b sf=%b",
                   e.name, result, zero, sf, e.res, e.z, e.s);
        end
      end
    end
  end

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sbv;
    logic [63:0] p;
    logic [4:0]  sh;
    logic        ovf;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    sh  = b[4:0];
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return a << sh;
      4'd7:  return a >> sh;
      4'd8:  return $signed(a) >>> sh;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return a * b;
      4'd11: begin p = 64'(sa * sbv); return p[63:32]; end
`ifdef SEQ_ALU_DIV_EN
      4'd12: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = 64'(sa / sbv); return p[31:0];
      end
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = 64'(sa % sbv); return p[31:0];
      end
      4'd15: return (b == 0) ? a : a % b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_iter(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o == 4'd10 || o == 4'd11) return 1'b1;
`ifdef SEQ_ALU_DIV_EN
    if (o >= 4'd12)
      return !(b == 0 || ((o == 4'd12 || o == 4'd14) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`endif
    return 1'b0;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input string name);
    int lat;
    int guard;
    int exp_lat;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1; op = o; src_a = a; src_b = b;
    sb.push_back('{exp_r, exp_r == 32'd0, b > a, name});
    exp_lat = is_iter(o, a, b) ? W + 1 : 1;
    @(negedge clk);
    start = 1'b0;
    if (exp_lat > 1) check({name, "_busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int dones;
    reset_n = 1'b0; start = 1'b0; op = 4'd0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_sf", 32'(sf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "add_wrap"});
    vecs.push_back('{4'd1,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, "sub_neg"});
    vecs.push_back('{4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, "and"});
    vecs.push_back('{4'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, "or"});
    vecs.push_back('{4'd4,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, "xor"});
    vecs.push_back('{4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt_m1_1"});
    vecs.push_back('{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu_m1_1"});
    vecs.push_back('{4'd6,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, "sll_upper_ignored"});
    vecs.push_back('{4'd7,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, "srl"});
    vecs.push_back('{4'd8,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra_0x24"});
    vecs.push_back('{4'd10, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3"});
    vecs.push_back('{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1_m1"});
    vecs.push_back('{4'd11, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, "mulh_max"});
    vecs.push_back('{4'd11, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "mulh_7_m3"});
    vecs.push_back('{4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "mul_low_zero"});
`ifdef SEQ_ALU_DIV_EN
    vecs.push_back('{4'd12, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2"});
    vecs.push_back('{4'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_m7_2"});
    vecs.push_back('{4'd13, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "divu_by0"});
    vecs.push_back('{4'd15, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "remu_by0"});
    vecs.push_back('{4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"});
    vecs.push_back('{4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf"});
    vecs.push_back('{4'd13, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, "divu_100_7"});
    vecs.push_back('{4'd15, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, "remu_100_7"});
    vecs.push_back('{4'd12, 32'h0000_000A, 32'h0000_0002, 32'h0000_0005, "div_10_2"});
    vecs.push_back('{4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "divu_big"});
`else
    vecs.push_back('{4'd12, 32'h0000_000A, 32'h0000_0002, 32'h0000_0000, "div_disabled"});
    vecs.push_back('{4'd15, 32'h0000_0064, 32'h0000_0007, 32'h0000_0000, "remu_disabled"});
`endif

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].name);

    // Back-to-back quick ops: done on two consecutive cycles.
    @(negedge clk);
    start = 1'b1; op = 4'd0; src_a = 32'hFFFF_FFFF; src_b = 32'h1;
    sb.push_back('{32'h0, 1'b1, 1'b0, "b2b_add"});
    @(negedge clk);
    check("b2b_add_done", 32'(done), 32'd1);
    op = 4'd1; src_a = 32'd3; src_b = 32'd5;
    sb.push_back('{32'hFFFF_FFFE, 1'b0, 1'b1, "b2b_sub"});
    @(negedge clk);
    start = 1'b0;
    check("b2b_sub_done", 32'(done), 32'd1);
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);

    // Quick op started in the same cycle as a multi-cycle done.
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, "mulh_k33");
    run_op(4'd0, 32'd5, 32'd6, 32'd11, "add_on_done");

    // start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; op = 4'd10; src_a = 32'd7; src_b = 32'hFFFF_FFFD;
    sb.push_back('{32'hFFFF_FFEB, 1'b0, 1'b1, "mul_ignore_start"});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 4'd0; src_a = 32'd1; src_b = 32'd1;
    @(negedge clk);
    start = 1'b0; src_a = '0; src_b = '0;
    lat = 4;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("mul_ignore_start_latency", lat, W + 1);
    repeat (3) @(negedge clk);

    // Random vectors against the reference model.
    for (int i = 0; i < 48; i++) begin
      logic [3:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 3) rb = 32'd0;
      if (i % 8 == 5) rb = ra;
      if (i % 8 == 6) rb = {27'd0, rb[4:0]};
      run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d_op%0d", i, ro));
    end

    // Reset mid-MUL aborts without done.
    run_op(4'd0, 32'd1, 32'd2, 32'd3, "pre_reset_add");
    start = 1'b1; op = 4'd10; src_a = 32'd123; src_b = 32'd456;
    sb.push_back('{32'd56088, 1'b0, 1'b1, "aborted_mul"});
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_mul_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_zero", 32'(zero), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no_done_after_abort", dones, 0);
    check("result_held_after_abort", result, 32'd0);
    run_op(4'd10, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_after_reset");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
